// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan speed sequencer: speed codes, FSM states,
// default timing parameters and the LED decode helper.
package fan_ctrl_pkg;

  localparam logic [1:0] SPEED_OFF  = 2'd0;
  localparam logic [1:0] SPEED_LOW  = 2'd1;
  localparam logic [1:0] SPEED_MID  = 2'd2;
  localparam logic [1:0] SPEED_HIGH = 2'd3;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_RUN  = 2'd2
  } fan_state_e;

  localparam int DEF_RAMP_TICKS = 2;
  localparam int DEF_TIME_STEP  = 5;
  localparam int DEF_TIME_MAX   = 30;

  function automatic logic [3:0] level_onehot(input logic [1:0] lvl);
    level_onehot = 4'b0001 << lvl;
  endfunction

endpackage

// File: rtl/fan_countdown_timer.sv
// Auto-off timer: preset adjust, remaining-units countdown and one-cycle expiry pulse.
// expire_now is the combinational expiry event so the speed FSM can act on the same edge.
module fan_countdown_timer
  import fan_ctrl_pkg::*;
#(
  parameter int TIME_STEP = DEF_TIME_STEP,
  parameter int TIME_MAX  = DEF_TIME_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_plus,
  input  logic       btn_minus,
  input  logic       btn_off,
  input  logic       timer_mode,
  input  logic       tick,
  input  logic       fan_on,
  output logic       expire_now,
  output logic [4:0] remaining,
  output logic       expired
);

  localparam logic [5:0] STEP  = 6'(TIME_STEP);
  localparam logic [5:0] LIMIT = 6'(TIME_MAX);

  logic [4:0] preset_r, preset_nx;
  logic [4:0] remaining_r, remaining_nx;
  logic       expired_r;
  logic       mode_prev_r;
  logic [5:0] sum_s;
  logic [4:0] up_val_s, dn_val_s;
  logic       plus_ok_s, minus_ok_s, mode_fall_s, dec_s;

  // Next preset/remaining; expiry outranks clear, clear outranks adjust, adjust outranks countdown
  always_comb begin
    plus_ok_s   = timer_mode & btn_plus & ~btn_minus;
    minus_ok_s  = timer_mode & btn_minus & ~btn_plus;
    sum_s       = {1'b0, preset_r} + STEP;
    up_val_s    = (sum_s > LIMIT) ? LIMIT[4:0] : sum_s[4:0];
    dn_val_s    = ({1'b0, preset_r} > STEP) ? (preset_r - STEP[4:0]) : 5'd0;
    mode_fall_s = mode_prev_r & ~timer_mode;
    dec_s       = tick & timer_mode & fan_on & (remaining_r != 5'd0);
    expire_now  = dec_s & (remaining_r == 5'd1);
    preset_nx    = preset_r;
    remaining_nx = remaining_r;
    if (expire_now) begin
      remaining_nx = 5'd0;
    end else if (mode_fall_s | btn_off) begin
      preset_nx    = 5'd0;
      remaining_nx = 5'd0;
    end else if (plus_ok_s) begin
      preset_nx    = up_val_s;
      remaining_nx = up_val_s;
    end else if (minus_ok_s) begin
      preset_nx    = dn_val_s;
      remaining_nx = dn_val_s;
    end else if (dec_s) begin
      remaining_nx = remaining_r - 5'd1;
    end else begin
      remaining_nx = remaining_r;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_r    <= 5'd0;
      remaining_r <= 5'd0;
      expired_r   <= 1'b0;
      mode_prev_r <= 1'b0;
    end else begin
      preset_r    <= preset_nx;
      remaining_r <= remaining_nx;
      expired_r   <= expire_now;
      mode_prev_r <= timer_mode;
    end
  end

  assign remaining = remaining_r;
  assign expired   = expired_r;

endmodule

// File: rtl/fan_speed_sequencer.sv
// Fan speed sequencer: button-driven target speed, tick-paced upward ramp of the
// applied PWM level, immediate step-down, and an optional auto-off timer.
module fan_speed_sequencer
  import fan_ctrl_pkg::*;
#(
  parameter int RAMP_TICKS = DEF_RAMP_TICKS,
  parameter int TIME_STEP  = DEF_TIME_STEP,
  parameter int TIME_MAX   = DEF_TIME_MAX
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_off,
  input  logic       i_btn_plus,
  input  logic       i_btn_minus,
  input  logic       i_timer_mode,
  input  logic       i_tick,
  output logic [1:0] o_target,
  output logic [1:0] o_pwm_sel,
  output logic [4:0] o_remaining,
  output logic       o_expired,
  output logic [3:0] o_led
);

  localparam int CW = (RAMP_TICKS > 2) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_TICKS - 1);

  fan_state_e    state_r, state_nx;
  logic [1:0]    target_r, target_nx;
  logic [1:0]    pwm_r, pwm_nx, pwm_inc_s;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic          expire_now_s;

  fan_countdown_timer #(
    .TIME_STEP (TIME_STEP),
    .TIME_MAX  (TIME_MAX)
  ) u_timer (
    .clk        (i_clk),
    .rst        (i_reset),
    .btn_plus   (i_btn_plus),
    .btn_minus  (i_btn_minus),
    .btn_off    (i_btn_off),
    .timer_mode (i_timer_mode),
    .tick       (i_tick),
    .fan_on     (target_r != SPEED_OFF),
    .expire_now (expire_now_s),
    .remaining  (o_remaining),
    .expired    (o_expired)
  );

  // Target update and speed FSM; the applied level follows the new target on the same edge
  always_comb begin
    target_nx = target_r;
    pwm_nx    = pwm_r;
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    pwm_inc_s = pwm_r + 2'd1;

    if (expire_now_s | i_btn_off) begin
      target_nx = SPEED_OFF;
    end else if (i_btn_up & ~i_btn_down) begin
      target_nx = (target_r == SPEED_HIGH) ? SPEED_HIGH : (target_r + 2'd1);
    end else if (i_btn_down & ~i_btn_up) begin
      target_nx = (target_r == SPEED_OFF) ? SPEED_OFF : (target_r - 2'd1);
    end else begin
      target_nx = target_r;
    end

    if (target_nx < pwm_r) begin
      pwm_nx   = target_nx;
      cnt_nx   = '0;
      state_nx = (target_nx == SPEED_OFF) ? S_OFF : S_RUN;
    end else if (target_nx > pwm_r) begin
      // Already ramping: keep the tick count so a retargeted ramp is not restarted
      if (state_r != S_RAMP) begin
        state_nx = S_RAMP;
        cnt_nx   = '0;
      end else if (i_tick) begin
        if (cnt_r == CNT_LAST) begin
          pwm_nx   = pwm_inc_s;
          cnt_nx   = '0;
          state_nx = (pwm_inc_s == target_nx) ? S_RUN : S_RAMP;
        end else begin
          cnt_nx = cnt_r + CW'(1);
        end
      end else begin
        cnt_nx = cnt_r;
      end
    end else begin
      cnt_nx   = '0;
      state_nx = (pwm_r == SPEED_OFF) ? S_OFF : S_RUN;
    end
  end

  // Speed state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r  <= S_OFF;
      target_r <= SPEED_OFF;
      pwm_r    <= SPEED_OFF;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_nx;
      target_r <= target_nx;
      pwm_r    <= pwm_nx;
      cnt_r    <= cnt_nx;
    end
  end

  assign o_target  = target_r;
  assign o_pwm_sel = pwm_r;
  assign o_led     = level_onehot(pwm_r);

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Directed and randomized bench for fan_speed_sequencer, checked every cycle
// against an integer-level reference model of the speed/timer rules.
module tb_fan_speed_sequencer;

  localparam int RT = 2;
  localparam int TS = 5;
  localparam int TM = 30;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       up = 1'b0, down = 1'b0, off = 1'b0, plus = 1'b0, minus = 1'b0;
  logic       mode = 1'b0, tick = 1'b0;
  logic [1:0] o_target, o_pwm_sel;
  logic [4:0] o_remaining;
  logic       o_expired;
  logic [3:0] o_led;

  int checks = 0;
  int errors = 0;

  int m_target, m_pwm, m_cnt, m_ramping, m_preset, m_rem, m_exp, m_prev;

  fan_speed_sequencer #(.RAMP_TICKS(RT), .TIME_STEP(TS), .TIME_MAX(TM)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_btn_up     (up),
    .i_btn_down   (down),
    .i_btn_off    (off),
    .i_btn_plus   (plus),
    .i_btn_minus  (minus),
    .i_timer_mode (mode),
    .i_tick       (tick),
    .o_target     (o_target),
    .o_pwm_sel    (o_pwm_sel),
    .o_remaining  (o_remaining),
    .o_expired    (o_expired),
    .o_led        (o_led)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_target = 0; m_pwm = 0; m_cnt = 0; m_ramping = 0;
    m_preset = 0; m_rem = 0; m_exp = 0; m_prev = 0;
  endtask

  // One clock of the reference behaviour, using the inputs presented before the edge
  task automatic model_step();
    int  nt;
    bit  expire;
    expire = tick && mode && (m_target != 0) && (m_rem == 1);
    if (expire || off)           nt = 0;
    else if (up && !down)        nt = (m_target < 3) ? m_target + 1 : 3;
    else if (down && !up)        nt = (m_target > 0) ? m_target - 1 : 0;
    else                         nt = m_target;

    if (nt < m_pwm) begin
      m_pwm = nt; m_cnt = 0; m_ramping = 0;
    end else if (nt > m_pwm) begin
      if (!m_ramping) begin
        m_ramping = 1; m_cnt = 0;
      end else if (tick) begin
        m_cnt++;
        if (m_cnt == RT) begin
          m_pwm++; m_cnt = 0;
          if (m_pwm == nt) m_ramping = 0;
        end
      end
    end else begin
      m_ramping = 0; m_cnt = 0;
    end

    m_exp = expire ? 1 : 0;
    if (expire) begin
      m_rem = 0;
    end else if ((m_prev && !mode) || off) begin
      m_preset = 0; m_rem = 0;
    end else if (mode && plus && !minus) begin
      m_preset = (m_preset + TS > TM) ? TM : m_preset + TS;
      m_rem = m_preset;
    end else if (mode && minus && !plus) begin
      m_preset = (m_preset > TS) ? m_preset - TS : 0;
      m_rem = m_preset;
    end else if (tick && mode && m_target != 0 && m_rem > 0) begin
      m_rem--;
    end
    m_prev = mode;
    m_target = nt;
  endtask

  task automatic check_outputs();
    check_val("target", o_target, m_target);
    check_val("pwm_sel", o_pwm_sel, m_pwm);
    check_val("remaining", o_remaining, m_rem);
    check_val("expired", o_expired, m_exp);
    check_val("led", o_led, 1 << m_pwm);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    #1;
    check_outputs();
    up = 1'b0; down = 1'b0; off = 1'b0; plus = 1'b0; minus = 1'b0; tick = 1'b0;
  endtask

  task automatic press_up(input int n);    repeat (n) begin up = 1'b1; cyc(); end    endtask
  task automatic press_down(input int n);  repeat (n) begin down = 1'b1; cyc(); end  endtask
  task automatic press_plus(input int n);  repeat (n) begin plus = 1'b1; cyc(); end  endtask
  task automatic press_minus(input int n); repeat (n) begin minus = 1'b1; cyc(); end endtask
  task automatic ticks(input int n);       repeat (n) begin tick = 1'b1; cyc(); end  endtask

  // Async reset applied between edges; outputs must settle before any clock
  task automatic apply_reset();
    i_reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_led", o_led, 4'b0001);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset();

    // First press after reset honoured, then ramp to high
    press_up(1);
    check_val("first_up_target", o_target, 1);
    press_up(2);
    check_val("up3_target", o_target, 3);
    ticks(2); check_val("ramp_pwm1", o_pwm_sel, 1); check_val("ramp_led1", o_led, 4'b0010);
    ticks(2); check_val("ramp_pwm2", o_pwm_sel, 2); check_val("ramp_led2", o_led, 4'b0100);
    ticks(2); check_val("ramp_pwm3", o_pwm_sel, 3); check_val("ramp_led3", o_led, 4'b1000);

    // Step down is immediate, off returns to idle
    press_down(2);
    check_val("down2_pwm", o_pwm_sel, 1);
    off = 1'b1; cyc();
    check_val("off_pwm", o_pwm_sel, 0);

    // Timer countdown to expiry
    mode = 1'b1;
    press_up(1);
    press_plus(2);
    check_val("preset10", o_remaining, 10);
    ticks(9);
    check_val("rem1", o_remaining, 1);
    ticks(1);
    check_val("expired_pulse", o_expired, 1);
    check_val("expired_pwm", o_pwm_sel, 0);
    cyc();
    check_val("expired_one_cycle", o_expired, 0);

    // Preset saturation both ways, simultaneous plus/minus ignored
    press_plus(7);
    check_val("sat_max", o_remaining, 30);
    plus = 1'b1; minus = 1'b1; cyc();
    check_val("plus_minus_ignored", o_remaining, 30);
    press_minus(8);
    check_val("sat_zero", o_remaining, 0);

    // Expiry beats a same-cycle up press
    press_up(1);
    press_plus(1);
    ticks(4);
    up = 1'b1; tick = 1'b1; cyc();
    check_val("exp_vs_up_target", o_target, 0);
    check_val("exp_vs_up_pulse", o_expired, 1);
    press_up(1);
    check_val("up_after_exp", o_target, 1);

    // Zero remaining with timer on: runs indefinitely
    ticks(12);
    check_val("no_expiry_target", o_target, 1);

    // Mode falling clears the timer without expiry
    press_plus(2);
    mode = 1'b0; cyc();
    check_val("mode_fall_rem", o_remaining, 0);

    // Reset mid-ramp and mid-countdown
    off = 1'b1; cyc();
    mode = 1'b1;
    press_up(3);
    ticks(2);
    press_plus(2);
    ticks(3);
    check_val("pre_rst_pwm", o_pwm_sel, 2);
    check_val("pre_rst_rem", o_remaining, 7);
    apply_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      up    = ($urandom_range(0, 7) == 0);
      down  = ($urandom_range(0, 9) == 0);
      off   = ($urandom_range(0, 40) == 0);
      plus  = ($urandom_range(0, 8) == 0);
      minus = ($urandom_range(0, 12) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 60) == 0) mode = ~mode;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
